rr_mux_n_to_1: RTL



---
 rtl/rr_mux_n_to_1.sv | 104 ++++++++++
 1 files changed

// File: rtl/rr_mux_n_to_1.sv
// N-to-1 registered round-robin stream multiplexer with valid/ready handshakes.
// Optional RR_MUX_FORCE_EN adds force_en/force_sel to restrict the grant.
module rr_mux_n_to_1 #(
   parameter int N = 4,
   parameter int W = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [N*W-1:0]         in_data,
   input  logic [N-1:0]           in_valid,
   output logic [N-1:0]           in_ready,
   output logic [W-1:0]           out_data,
   output logic [$clog2(N)-1:0]   out_chan,
   output logic                   out_valid,
`ifdef RR_MUX_FORCE_EN
   input  logic                   force_en,
   input  logic [$clog2(N)-1:0]   force_sel,
`endif
   input  logic                   out_ready
);

   localparam int SELW = $clog2(N);

   logic [SELW-1:0] r_ptr;
   logic [SELW-1:0] r_chan;
   logic [W-1:0]    r_data;
   logic            r_valid;

   logic [N-1:0]    w_elig;
   logic            w_found;
   logic [SELW-1:0] w_grant;
   logic [SELW-1:0] w_ptr_nxt;
   logic            w_load_ok;
   logic            w_xfer;

   // Gating with rst_n keeps in_ready low while reset is held.
   assign w_load_ok = rst_n & (~r_valid | out_ready);

`ifdef RR_MUX_FORCE_EN
   logic [N-1:0] w_force_mask;

   always_comb begin
      w_force_mask = '0;
      for (int k = 0; k < N; k++) begin
         w_force_mask[k] = (int'(force_sel) == k);
      end
   end

   assign w_elig = force_en ? (in_valid & w_force_mask) : in_valid;
`else
   assign w_elig = in_valid;
`endif

   // First eligible channel searching upward from r_ptr with wrap.
   always_comb begin
      int v_idx;
      w_found = 1'b0;
      w_grant = '0;
      v_idx   = 0;
      for (int i = 0; i < N; i++) begin
         v_idx = int'(r_ptr) + i;
         if (v_idx >= N) begin
            v_idx = v_idx - N;
         end
         if (!w_found && w_elig[SELW'(v_idx)]) begin
            w_found = 1'b1;
            w_grant = SELW'(v_idx);
         end
      end
   end

   assign w_xfer    = w_load_ok & w_found;
   assign w_ptr_nxt = (w_grant == SELW'(N - 1)) ? '0 : w_grant + SELW'(1);

   always_comb begin
      in_ready = '0;
      if (w_xfer) begin
         in_ready[w_grant] = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ptr   <= '0;
         r_chan  <= '0;
         r_data  <= '0;
         r_valid <= 1'b0;
      end else if (w_load_ok) begin
         if (w_found) begin
            r_data  <= in_data[int'(w_grant) * W +: W];
            r_chan  <= w_grant;
            r_valid <= 1'b1;
            r_ptr   <= w_ptr_nxt;
         end else begin
            r_valid <= 1'b0;
         end
      end
   end

   assign out_data  = r_data;
   assign out_chan  = r_chan;
   assign out_valid = r_valid;

endmodule
